// File: rtl/cpu_status_reg.sv
// 6502-style processor status register (P) with delayed IRQ-inhibit view.
// Define CPU_STATUS_DECIMAL_EN to drive decimal_mode from D (else tied 0).
module cpu_status_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_en,
  input  logic [7:0] bit_data,
  input  logic       flag_op_en,
  input  logic [2:0] flag_op,
  input  logic       pull_en,
  input  logic [7:0] pull_data,
  input  logic       int_entry,
  input  logic       push_b,
  input  logic       instr_end,
  output logic [7:0] p_push,
  output logic [7:0] p_flags,
  output logic       carry_to_alu,
  output logic       irq_inhibit,
  output logic       decimal_mode
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic irq_q, irq_d;
  logic res_zero;

  assign res_zero = (alu_result == 8'h00);

  // Sources applied lowest priority first so later ones override.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (upd_nz) begin
      n_d = alu_result[7];
      z_d = res_zero;
    end
    if (upd_c) c_d = alu_carry;
    if (upd_v) v_d = alu_overflow;
    if (bit_en) begin
      n_d = bit_data[7];
      v_d = bit_data[6];
      z_d = res_zero;
    end
    if (flag_op_en) begin
      unique case (flag_op)
        3'd0:    c_d = 1'b0;
        3'd1:    c_d = 1'b1;
        3'd2:    i_d = 1'b0;
        3'd3:    i_d = 1'b1;
        3'd4:    v_d = 1'b0;
        3'd5:    d_d = 1'b0;
        3'd6:    d_d = 1'b1;
        default: ;
      endcase
    end
    if (int_entry) i_d = 1'b1;
    if (pull_en) begin
      n_d = pull_data[7];
      v_d = pull_data[6];
      d_d = pull_data[3];
      i_d = pull_data[2];
      z_d = pull_data[1];
      c_d = pull_data[0];
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (int_entry)      irq_d = 1'b1;
    else if (instr_end) irq_d = i_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q   <= RESET_P[7];
      v_q   <= RESET_P[6];
      d_q   <= RESET_P[3];
      i_q   <= RESET_P[2];
      z_q   <= RESET_P[1];
      c_q   <= RESET_P[0];
      irq_q <= 1'b1;
    end else begin
      n_q   <= n_d;
      v_q   <= v_d;
      d_q   <= d_d;
      i_q   <= i_d;
      z_q   <= z_d;
      c_q   <= c_d;
      irq_q <= irq_d;
    end
  end

  assign p_flags      = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign p_push       = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};
  assign carry_to_alu = c_q;
  assign irq_inhibit  = irq_q;

`ifdef CPU_STATUS_DECIMAL_EN
  assign decimal_mode = d_q;
`else
  assign decimal_mode = 1'b0;
`endif

endmodule
